// File: rtl/conv_stream_pkg.sv
// Shared FSM state encoding and watchdog default for the convolution stream host.
package conv_stream_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_STREAM,
        ST_DRAIN,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/conv_stream_host_if.sv
// Host <-> convolution engine stream handshake: x toward the engine, y back from it.
interface conv_stream_host_if #(
    parameter int unsigned T = 16
);
    logic [T-1:0] x_data;
    logic         x_valid;
    logic         x_ready;
    logic [T-1:0] y_data;
    logic         y_valid;
    logic         y_ready;

    modport master (
        output x_data, x_valid, y_ready,
        input  x_ready, y_data, y_valid
    );

    modport slave (
        input  x_data, x_valid, y_ready,
        output x_ready, y_data, y_valid
    );
endinterface

// File: rtl/conv_host_ram.sv
// Single-clock buffer: one write port, one registered read port (read-before-write).
module conv_host_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
        end
    end
endmodule

// File: rtl/conv_stream_host.sv
// Buffers an input vector, streams it to a convolution engine and captures the results.
// Optional stall injection on the handshakes: define CONV_STREAM_HOST_STALL_EN.
module conv_stream_host
    import conv_stream_pkg::*;
#(
    parameter int unsigned T       = 16,
    parameter int unsigned SIZE_X  = 32,
    parameter int unsigned SIZE_F  = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    localparam int unsigned SIZE_Y = SIZE_X - SIZE_F + 1,
    localparam int unsigned XAW    = $clog2(SIZE_X),
    localparam int unsigned YAW    = $clog2(SIZE_Y),
    localparam int unsigned XCW    = XAW + 1,
    localparam int unsigned YCW    = YAW + 1,
    localparam int unsigned WDW    = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_wr_en,
    input  logic [XAW-1:0]      in_wr_addr,
    input  logic [T-1:0]        in_wr_data,
    input  logic [YAW-1:0]      out_rd_addr,
    output logic [T-1:0]        out_rd_data,
    conv_stream_host_if.master  eng,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic [YCW-1:0]      y_count
);
    state_t           state_q, state_d;
    logic [XCW-1:0]   x_cnt_q, x_cnt_d;
    logic [YCW-1:0]   y_count_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             x_valid_q, x_valid_d;
    logic             y_ready_q, y_ready_d;
    logic             busy_d, done_d, timeout_err_d;
    logic             x_hs_c, y_hs_c, gate_x_c, gate_y_c, x_rd_en_c;
    logic [XCW-1:0]   x_next_idx_c;
    logic [XAW-1:0]   x_rd_addr_c;

`ifdef CONV_STREAM_HOST_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign gate_x_c = lfsr_q[0];
    assign gate_y_c = lfsr_q[1];
`else
    assign gate_x_c = 1'b0;
    assign gate_y_c = 1'b0;
`endif

    assign x_hs_c = x_valid_q && eng.x_ready;
    assign y_hs_c = eng.y_valid && y_ready_q && (y_count < YCW'(SIZE_Y));

    // Read-ahead: address the word after the one being accepted so it appears with no bubble.
    always_comb begin
        x_next_idx_c = x_hs_c ? (x_cnt_q + XCW'(1)) : x_cnt_q;
        x_rd_addr_c  = (x_next_idx_c < XCW'(SIZE_X)) ? x_next_idx_c[XAW-1:0] : '0;
        x_rd_en_c    = (state_q == ST_PREFETCH) || (state_q == ST_STREAM);
    end

    conv_host_ram #(.WIDTH(T), .DEPTH(SIZE_X)) u_in_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_wr_en && (state_q == ST_IDLE)),
        .wr_addr (in_wr_addr),
        .wr_data (in_wr_data),
        .rd_en   (x_rd_en_c),
        .rd_addr (x_rd_addr_c),
        .rd_data (eng.x_data)
    );

    conv_host_ram #(.WIDTH(T), .DEPTH(SIZE_Y)) u_out_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (y_hs_c),
        .wr_addr (y_count[YAW-1:0]),
        .wr_data (eng.y_data),
        .rd_en   (1'b1),
        .rd_addr (out_rd_addr),
        .rd_data (out_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_cnt_q     <= '0;
            y_count     <= '0;
            wd_q        <= '0;
            x_valid_q   <= 1'b0;
            y_ready_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_cnt_q     <= x_cnt_d;
            y_count     <= y_count_d;
            wd_q        <= wd_d;
            x_valid_q   <= x_valid_d;
            y_ready_q   <= y_ready_d;
            busy        <= busy_d;
            done        <= done_d;
            timeout_err <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        x_cnt_d       = x_cnt_q;
        y_count_d     = y_count;
        wd_d          = wd_q;
        timeout_err_d = timeout_err;
        x_valid_d     = 1'b0;

        if (x_hs_c) x_cnt_d = x_cnt_q + XCW'(1);
        if (y_hs_c) y_count_d = y_count + YCW'(1);
        if (state_q != ST_IDLE) wd_d = (x_hs_c || y_hs_c) ? '0 : (wd_q + WDW'(1));

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_PREFETCH;
                    x_cnt_d       = '0;
                    y_count_d     = '0;
                    wd_d          = '0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_PREFETCH: begin
                state_d   = ST_STREAM;
                x_valid_d = !gate_x_c;
            end
            ST_STREAM: begin
                if (x_hs_c && (x_cnt_q == XCW'(SIZE_X - 1))) begin
                    state_d = ST_DRAIN;
                end else begin
                    // A presented word stays valid until taken; stalls only delay new words.
                    x_valid_d = (x_valid_q && !x_hs_c) || !gate_x_c;
                end
            end
            ST_DRAIN: begin
                if (y_count == YCW'(SIZE_Y)) state_d = ST_FINISH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && !(x_hs_c || y_hs_c) && ((32'(wd_q) + 32'd1) >= TIMEOUT)) begin
            state_d       = ST_IDLE;
            timeout_err_d = 1'b1;
            x_valid_d     = 1'b0;
            wd_d          = '0;
        end

        done_d    = (state_d == ST_FINISH);
        busy_d    = (state_d != ST_IDLE);
        y_ready_d = ((state_d == ST_STREAM) || (state_d == ST_DRAIN)) &&
                    (y_count_d < YCW'(SIZE_Y)) && !gate_y_c;
    end

    assign eng.x_valid = x_valid_q;
    assign eng.y_ready = y_ready_q;
endmodule

// File: tb/tb_conv_stream_host.sv
// Directed bench for conv_stream_host with a 32/8 all-ones-filter engine model.
module tb_conv_stream_host;
    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_wr_en = 1'b0;
    logic [4:0]  in_wr_addr = '0;
    logic [15:0] in_wr_data = '0;
    logic [4:0]  out_rd_addr = '0;
    logic [15:0] out_rd_data;
    logic        busy, done, timeout_err;
    logic [5:0]  y_count;

    conv_stream_host_if #(.T(T)) eif ();

    conv_stream_host #(.T(T), .SIZE_X(32), .SIZE_F(8), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_wr_en    (in_wr_en),
        .in_wr_addr  (in_wr_addr),
        .in_wr_data  (in_wr_data),
        .out_rd_addr (out_rd_addr),
        .out_rd_data (out_rd_data),
        .eng         (eif.master),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .y_count     (y_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    ylimit;
        int    stall_at;
        int    stall_len;
        bit    inject;
        bit    exp_done;
        bit    exp_tout;
        int    exp_ycount;
    } vec_t;

    int total = 0;
    int bad = 0;

    // engine configuration (written by the stimulus only)
    int eng_ylimit = 25;
    int eng_stall_at = -1;
    int eng_stall_len = 0;

    // monitor state (written by the posedge monitor only)
    int          cyc = 0;
    int          rx_cnt = 0;
    int          ytx = 0;
    logic [15:0] rx_buf [32];
    int          done_cnt = 0;
    int          first_x = -1, last_x = -1, last_hs = -1, err_rise = -1;
    int          stall_cnt = 0, stall_bad = 0, viol = 0;
    logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
    logic [15:0] pd = '0;

    // engine drive state (written by the negedge engine only)
    int          stalled = 0;
    logic [15:0] acc;

    always @(posedge clk) begin
        cyc++;
        if (!reset && !prst && pv && !pr && (!eif.x_valid || eif.x_data != pd)) viol++;
        pv = eif.x_valid; pr = eif.x_ready; pd = eif.x_data; prst = reset;
        if (reset || (start && !busy)) begin
            rx_cnt = 0; ytx = 0; done_cnt = 0;
            first_x = -1; last_x = -1; last_hs = -1; err_rise = -1;
            stall_cnt = 0; stall_bad = 0;
        end else begin
            if (eif.x_valid && !eif.x_ready) begin
                stall_cnt++;
                if (eif.x_data != 16'(rx_cnt + 1)) stall_bad++;
            end
            if (eif.x_valid && eif.x_ready) begin
                if (rx_cnt < 32) rx_buf[rx_cnt] = eif.x_data;
                rx_cnt++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                last_hs = cyc;
            end
            if (eif.y_valid && eif.y_ready) begin
                ytx++;
                last_hs = cyc;
            end
            if (done) done_cnt++;
            if (timeout_err && err_rise < 0) err_rise = cyc - 1;
        end
    end

    // Engine: optional x stall, then emits y[j] = sum of x[j..j+7] once those words arrived.
    always @(negedge clk) begin
        if (rx_cnt == 0) stalled = 0;
        if (rx_cnt == eng_stall_at && stalled < eng_stall_len) begin
            eif.x_ready = 1'b0;
            stalled++;
        end else begin
            eif.x_ready = 1'b1;
        end
        if (ytx < eng_ylimit && rx_cnt >= ytx + 8 && ytx + 8 <= 32) begin
            acc = '0;
            for (int k = 0; k < 8; k++) acc = acc + rx_buf[ytx + k];
            eif.y_valid = 1'b1;
            eif.y_data  = acc;
        end else begin
            eif.y_valid = 1'b0;
            eif.y_data  = '0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_x_valid"}, eif.x_valid, 0);
        check({tag, "_y_ready"}, eif.y_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_y_count"}, y_count, 0);
        check({tag, "_x_data"}, eif.x_data, 0);
    endtask

    task automatic run_row(input vec_t v);
        int  waited;
        int  order_err;
        bit  injected;
        eng_ylimit    = v.ylimit;
        eng_stall_at  = v.stall_at;
        eng_stall_len = v.stall_len;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        waited = 0;
        injected = 1'b0;
        while (done_cnt == 0 && !timeout_err && waited < 1000) begin
            @(negedge clk);
            waited++;
            if (v.inject && !injected && rx_cnt >= 5) begin
                start = 1'b1; in_wr_en = 1'b1; in_wr_addr = 5'd20; in_wr_data = 16'hDEAD;
                @(negedge clk);
                start = 1'b0; in_wr_en = 1'b0;
                injected = 1'b1;
            end
        end
        check({v.name, "_finished"}, waited < 1000, 1);
        repeat (3) @(negedge clk);
        check({v.name, "_done_pulses"}, done_cnt, v.exp_done ? 1 : 0);
        check({v.name, "_timeout_err"}, timeout_err, v.exp_tout ? 1 : 0);
        check({v.name, "_busy"}, busy, 0);
        check({v.name, "_y_count"}, y_count, v.exp_ycount);
        check({v.name, "_x_words"}, rx_cnt, 32);
        order_err = 0;
        for (int i = 0; i < 32; i++) if (rx_buf[i] != 16'(i + 1)) order_err++;
        check({v.name, "_x_order_errors"}, order_err, 0);
        check({v.name, "_stall_data_errors"}, stall_bad, 0);
`ifndef CONV_STREAM_HOST_STALL_EN
        check({v.name, "_x_span"}, last_x - first_x, 31 + v.stall_len);
        check({v.name, "_stall_cycles"}, stall_cnt, v.stall_len);
`endif
        if (v.exp_tout) begin
            check({v.name, "_latency"}, err_rise - last_hs, 64);
            check({v.name, "_x_valid"}, eif.x_valid, 0);
            check({v.name, "_y_ready"}, eif.y_ready, 0);
        end
        for (int j = 0; j < v.exp_ycount; j++) begin
            @(negedge clk) out_rd_addr = 5'(j);
            @(negedge clk) check($sformatf("%s_y%0d", v.name, j), out_rd_data, 8 * j + 36);
        end
    endtask

    initial begin
        vec_t vecs [4];
        int   waited;
        vecs[0] = '{"basic",       25, -1, 0, 1'b0, 1'b1, 1'b0, 25};
        vecs[1] = '{"xstall",      25, 10, 5, 1'b0, 1'b1, 1'b0, 25};
        vecs[2] = '{"busy_ignore", 25, -1, 0, 1'b1, 1'b1, 1'b0, 25};
        vecs[3] = '{"timeout",     24, -1, 0, 1'b0, 1'b0, 1'b1, 24};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            in_wr_en = 1'b1; in_wr_addr = 5'(i); in_wr_data = 16'(i + 1);
        end
        @(negedge clk) in_wr_en = 1'b0;

        for (int r = 0; r < 4; r++) run_row(vecs[r]);

        // Sticky error clears on the next start; then reset mid-stream and restart.
        eng_ylimit = 25; eng_stall_at = -1; eng_stall_len = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("restart_clears_timeout_err", timeout_err, 0);
        check("restart_busy", busy, 1);
        waited = 0;
        while (rx_cnt < 7 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("midrun_reached_word7", rx_cnt >= 7, 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrun_reset");
        @(negedge clk) reset = 1'b0;
        run_row(vecs[0]);

        check("handshake_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
